// File: rtl/uart_rx_cfg_if.sv
// Receive-side word handshake between the UART receiver and its consumer.
interface uart_rx_cfg_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] parallel_out;
    logic                 data_valid;
    logic                 data_ack;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun_err;

    // Receiver side: produces words and flags, consumes the ack.
    modport master (
        output parallel_out,
        output data_valid,
        output parity_err,
        output frame_err,
        output overrun_err,
        input  data_ack
    );

    // Consumer side.
    modport slave (
        input  parallel_out,
        input  data_valid,
        input  parity_err,
        input  frame_err,
        input  overrun_err,
        output data_ack
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: glitch-filtered start detection, configurable data width,
// parity and stop bits, parity/framing/overrun flags and a valid/ack word handshake.
module uart_rx_cfg #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD      = 115_200,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          serial_in_i,
    output logic          busy_o,
    uart_rx_cfg_if.master rx_if
);
    localparam int unsigned CPB  = CLK_FREQ / BAUD;
    localparam int unsigned HALF = CPB / 2;
    localparam int unsigned CntW = $clog2(CPB) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitHigh
    } state_e;

    logic                 sync1_q, sync2_q;
    logic                 rx_s;
    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 commit_q, commit_d;
    logic                 tick;

    logic [DATA_BITS-1:0] pout_q;
    logic                 valid_q, pe_q, fe_q, ov_q;

    assign rx_s = sync2_q;

    // Two-flop synchroniser for the asynchronous line; resets to idle-high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= serial_in_i;
            sync2_q <= sync1_q;
        end
    end

    // Frame FSM and datapath state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            commit_q <= commit_d;
        end
    end

    // Next-state logic: the counter reloads on every sample, so it never wraps.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        commit_d = 1'b0;
        tick     = (state_q == StStart) ? (cnt_q == CntW'(HALF - 1))
                                        : (cnt_q == CntW'(CPB - 1));

        if (state_q != StIdle && state_q != StWaitHigh) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    state_d = StStart;
                    cnt_d   = '0;
                    bit_d   = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            StStart: begin
                // A line that is high again at mid start bit was a glitch.
                if (tick) state_d = rx_s ? StIdle : StData;
            end
            StData: begin
                if (tick) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_q == 4'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (tick) begin
                    perr_d  = ((^shift_q) ^ rx_s) != (PARITY == 1);
                    state_d = StStop;
                end
            end
            StStop: begin
                if (tick) begin
                    if (!rx_s) ferr_d = 1'b1;
                    if (bit_q == 4'(STOP_BITS - 1)) begin
                        commit_d = 1'b1;
                        // Leave mid stop bit so back-to-back frames are caught.
                        state_d  = (ferr_q || !rx_s) ? StWaitHigh : StIdle;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            StWaitHigh: begin
                // Swallow a break: only one word until the line returns high.
                if (rx_s) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Word commit and handshake; a commit wins over a same-cycle ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pout_q  <= '0;
            valid_q <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            ov_q <= 1'b0;
            if (commit_q) begin
                pout_q  <= shift_q;
                pe_q    <= perr_q;
                fe_q    <= ferr_q;
                valid_q <= 1'b1;
                ov_q    <= valid_q & ~rx_if.data_ack;
            end else if (rx_if.data_ack) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_if.parallel_out = pout_q;
    assign rx_if.data_valid   = valid_q;
    assign rx_if.parity_err   = pe_q;
    assign rx_if.frame_err    = fe_q;
    assign rx_if.overrun_err  = ov_q;
    assign busy_o             = (state_q != StIdle);

endmodule
